load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/header_pkg.sv | 47 ++++
 rtl/lsu_load_align.sv | 26 ++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/header_pkg.sv
// rtl/header_pkg.sv - shared enums and lane helpers for the load/store unit.
package header_pkg;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU
    } alu_ops_t;

    typedef enum logic [3:0] {
        MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU,
        MEM_SB, MEM_SH, MEM_SW
    } mem_op_t;

    typedef enum logic [1:0] {
        IDLE, REQ, WAIT
    } lsu_state_t;

    function automatic logic lsu_is_store(input mem_op_t op);
        return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
    endfunction

    function automatic logic [3:0] lsu_be(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_SB:  return 4'b0001 << off;
            MEM_SH:  return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data is replicated so the byte enables alone pick the lane.
    function automatic logic [31:0] lsu_wdata(input mem_op_t op, input logic [31:0] d);
        case (op)
            MEM_SB:  return {4{d[7:0]}};
            MEM_SH:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input mem_op_t op, input logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return off[0];
            MEM_LW, MEM_SW:          return |off;
            default:                 return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// rtl/lsu_load_align.sv - selects the load lane from a word and sign/zero extends it.
module lsu_load_align
    import header_pkg::*;
(
    input  mem_op_t     op_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[{off_i, 3'b000} +: 8];
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            MEM_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
            MEM_LBU: data_o = {24'h0, byte_sel};
            MEM_LH:  data_o = {{16{half_sel[15]}}, half_sel};
            MEM_LHU: data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with response timeout.
// Optional LSU_MISALIGN_TRAP_EN adds the misalign port and rejects unaligned ops.
module load_store_unit
    import header_pkg::*;
#(
    parameter int RSP_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  mem_op_t     mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        st_done,
`ifdef LSU_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        err
);

    localparam int CNT_W = $clog2(RSP_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RSP_TIMEOUT - 1);

    lsu_state_t     state_q;
    mem_op_t        op_q;
    logic [1:0]     off_q;
    logic [4:0]     rd_q;
    logic [CNT_W-1:0] cnt_q;
    logic           dmem_req_q, dmem_we_q, wb_valid_q, st_done_q, err_q;
    logic [31:0]    dmem_addr_q, dmem_wdata_q, wb_data_q;
    logic [3:0]     dmem_be_q;
    logic [4:0]     wb_rd_q;

    logic           accept;
    logic           trap;
    logic [3:0]     be_d;
    logic [31:0]    wdata_d;
    logic [31:0]    load_d;

    assign accept  = (state_q == IDLE) && ex_valid && (mem_op != MEM_NONE);
    assign be_d    = lsu_be(mem_op, addr[1:0]);
    assign wdata_d = lsu_wdata(mem_op, wdata);

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign trap     = lsu_misaligned(mem_op, addr[1:0]);
    assign misalign = misalign_q;
`else
    assign trap = 1'b0;
`endif

    lsu_load_align u_align (
        .op_i    (op_q),
        .off_i   (off_q),
        .rdata_i (dmem_rdata),
        .data_o  (load_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            op_q         <= MEM_NONE;
            off_q        <= 2'b00;
            rd_q         <= 5'd0;
            cnt_q        <= '0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= 32'h0;
            dmem_be_q    <= 4'h0;
            dmem_wdata_q <= 32'h0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_data_q    <= 32'h0;
            st_done_q    <= 1'b0;
            err_q        <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            st_done_q  <= 1'b0;
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_q <= accept && trap;
`endif
            case (state_q)
                IDLE: begin
                    if (accept && !trap) begin
                        op_q         <= mem_op;
                        off_q        <= addr[1:0];
                        rd_q         <= rd;
                        dmem_req_q   <= 1'b1;
                        dmem_we_q    <= lsu_is_store(mem_op);
                        dmem_addr_q  <= {addr[31:2], 2'b00};
                        dmem_be_q    <= be_d;
                        dmem_wdata_q <= wdata_d;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    if (dmem_gnt) begin
                        dmem_req_q <= 1'b0;
                        if (lsu_is_store(op_q)) begin
                            st_done_q <= 1'b1;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // A response arriving on the final allowed cycle still wins over the timeout.
                    if (dmem_rvalid) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= load_d;
                        state_q    <= IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ex_ready   = (state_q == IDLE);
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign st_done    = st_done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit.
module tb_load_store_unit;
    import header_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    mem_op_t     mem_op;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        wb_valid, st_done, err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    load_store_unit #(.RSP_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
        .mem_op(mem_op), .addr(addr), .wdata(wdata), .rd(rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .st_done(st_done),
`ifdef LSU_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .err(err)
    );

    localparam logic [1:0] EV_WB = 2'd0, EV_ST = 2'd1, EV_ERR = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic [4:0]  rd;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_wd;
    } req_t;

    ev_t  ev_q[$];
    req_t req_q[$];
    int   n_tests = 0;
    int   n_fails = 0;
    int   req_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_req(input logic we, input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] wd, input logic chk_wd);
        req_t r;
        r.we = we; r.addr = a; r.be = be; r.wdata = wd; r.chk_wd = chk_wd;
        req_q.push_back(r);
    endtask

    task automatic exp_ev(input logic [1:0] kind, input logic [4:0] r, input logic [31:0] d);
        ev_t e;
        e.kind = kind; e.rd = r; e.data = d;
        ev_q.push_back(e);
    endtask

    task automatic issue(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        int n = 0;
        while (!ex_ready && n < 50) begin
            step();
            n++;
        end
        if (!ex_ready) chk("issue_ready_timeout", ex_ready, 1'b1);
        ex_valid = 1'b1; mem_op = op; addr = a; wdata = d; rd = r;
        step();
        ex_valid = 1'b0; mem_op = MEM_NONE;
    endtask

    task automatic grant(input int delay);
        for (int i = 0; i < delay; i++) step();
        dmem_gnt = 1'b1;
        step();
        dmem_gnt = 1'b0;
    endtask

    task automatic respond(input logic [31:0] d);
        dmem_rvalid = 1'b1; dmem_rdata = d;
        step();
        dmem_rvalid = 1'b0;
    endtask

    task automatic do_load(input mem_op_t op, input logic [31:0] a, input logic [4:0] r,
                           input logic [31:0] rdata, input logic [31:0] expd);
        exp_req(1'b0, {a[31:2], 2'b00}, 4'hF, 32'h0, 1'b0);
        exp_ev(EV_WB, r, expd);
        issue(op, a, 32'h0, r);
        grant(0);
        respond(rdata);
        chk("load_latency3_wb_valid", wb_valid, 1'b1);
    endtask

    task automatic do_store(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] be, input logic [31:0] wd, input int delay);
        exp_req(1'b1, {a[31:2], 2'b00}, be, wd, 1'b1);
        exp_ev(EV_ST, 5'd0, 32'h0);
        issue(op, a, d, 5'd0);
        grant(delay);
        chk("store_st_done", st_done, 1'b1);
    endtask

    // Monitor: checks every request cycle and every response pulse against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                if (dmem_req) begin
                    req_cycles++;
                    if (req_q.size() == 0) chk("req_unexpected", dmem_req, 1'b0);
                    else begin
                        chk("req_we", dmem_we, req_q[0].we);
                        chk("req_addr", dmem_addr, req_q[0].addr);
                        chk("req_be", dmem_be, req_q[0].be);
                        if (req_q[0].chk_wd) chk("req_wdata", dmem_wdata, req_q[0].wdata);
                        if (dmem_gnt) void'(req_q.pop_front());
                    end
                end
                if (wb_valid || st_done || err) begin
                    if (ev_q.size() == 0) begin
                        chk("event_unexpected_wb", wb_valid, 1'b0);
                        chk("event_unexpected_st", st_done, 1'b0);
                        chk("event_unexpected_err", err, 1'b0);
                    end else begin
                        ev_t e;
                        e = ev_q.pop_front();
                        chk("ev_wb_valid", wb_valid, e.kind == EV_WB);
                        chk("ev_st_done", st_done, e.kind == EV_ST);
                        chk("ev_err", err, e.kind == EV_ERR);
                        if (e.kind == EV_WB) begin
                            chk("wb_rd", wb_rd, e.rd);
                            chk("wb_data", wb_data, e.data);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int snap;
        rst = 1'b1; ex_valid = 1'b0; mem_op = MEM_NONE; addr = 0; wdata = 0; rd = 0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 0;
        step(); step();
        chk("rst_ex_ready", ex_ready, 1'b1);
        chk("rst_dmem_req", dmem_req, 1'b0);
        chk("rst_dmem_we", dmem_we, 1'b0);
        chk("rst_dmem_addr", dmem_addr, 32'h0);
        chk("rst_dmem_be", dmem_be, 4'h0);
        chk("rst_dmem_wdata", dmem_wdata, 32'h0);
        chk("rst_wb", {wb_valid, st_done, err}, 3'b000);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_wb_rd", wb_rd, 5'd0);
        rst = 1'b0;
        step();

        // MEM_NONE and stray gnt/rvalid in IDLE are no-ops
        ex_valid = 1'b1; mem_op = MEM_NONE; dmem_gnt = 1'b1; dmem_rvalid = 1'b1;
        step();
        ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        chk("none_ex_ready", ex_ready, 1'b1);
        chk("none_dmem_req", dmem_req, 1'b0);

        do_store(MEM_SW, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 0);
        do_load(MEM_LB, 32'h103, 5'd5, 32'h80FFFFFF, 32'hFFFFFF80);
        do_load(MEM_LBU, 32'h103, 5'd6, 32'h80FFFFFF, 32'h00000080);

        snap = req_cycles;
        do_store(MEM_SH, 32'h102, 32'h1234, 4'b1100, 32'h12341234, 3);
        chk("sh_req_cycles", req_cycles - snap, 4);

        do_store(MEM_SB, 32'h101, 32'h000000AB, 4'b0010, 32'hABABABAB, 1);
        do_load(MEM_LH, 32'h102, 5'd7, 32'h80017FFF, 32'hFFFF8001);
        do_load(MEM_LHU, 32'h100, 5'd8, 32'h8001F00D, 32'h0000F00D);
        do_load(MEM_LW, 32'h104, 5'd0, 32'h12345678, 32'h12345678);

        // Timeout: 16 WAIT cycles without rvalid
        exp_req(1'b0, 32'h200, 4'hF, 32'h0, 1'b0);
        exp_ev(EV_ERR, 5'd0, 32'h0);
        issue(MEM_LW, 32'h200, 32'h0, 5'd9);
        grant(0);
        for (int i = 0; i < 15; i++) step();
        chk("to_err_early", err, 1'b0);
        chk("to_still_wait", ex_ready, 1'b0);
        step();
        chk("to_err_pulse", err, 1'b1);
        chk("to_ex_ready", ex_ready, 1'b1);
        chk("to_no_wb", wb_valid, 1'b0);
        step();
        chk("to_err_one_cycle", err, 1'b0);

        // rvalid on the timeout cycle wins
        exp_req(1'b0, 32'h204, 4'hF, 32'h0, 1'b0);
        exp_ev(EV_WB, 5'd10, 32'hCAFEF00D);
        issue(MEM_LW, 32'h204, 32'h0, 5'd10);
        grant(0);
        for (int i = 0; i < 15; i++) step();
        respond(32'hCAFEF00D);
        chk("tie_wb_valid", wb_valid, 1'b1);
        chk("tie_no_err", err, 1'b0);

        // Reset while waiting for the response
        exp_req(1'b0, 32'h300, 4'hF, 32'h0, 1'b0);
        issue(MEM_LW, 32'h300, 32'h0, 5'd11);
        grant(0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h55555555;
        step(); step();
        dmem_rvalid = 1'b0;
        chk("rstwait_no_wb", wb_valid, 1'b0);
        chk("rstwait_idle", ex_ready, 1'b1);
        chk("rstwait_no_req", dmem_req, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
        issue(MEM_LW, 32'h101, 32'h0, 5'd12);
        chk("mis_pulse", misalign, 1'b1);
        chk("mis_no_req", dmem_req, 1'b0);
        chk("mis_idle", ex_ready, 1'b1);
        step();
        chk("mis_one_cycle", misalign, 1'b0);
        chk("mis_still_no_req", dmem_req, 1'b0);
`endif

        step(); step(); step();
        chk("ev_q_drained", ev_q.size(), 0);
        chk("req_q_drained", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
